// File: rtl/generic_stat_regs_pkg.sv
// Shared ring widths, local-address decode constants and sizing helpers for generic_stat_regs.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package generic_stat_regs_pkg;

    localparam int RING_ADDR_W = `UDP_REG_ADDR_WIDTH;
    localparam int RING_DATA_W = `CPCI_NF2_DATA_WIDTH;

    // Counters start at local address 0; sw regs follow directly after them.
    localparam int CNTR_BASE = 0;

    function automatic int sw_base(input int num_cntrs);
        return CNTR_BASE + num_cntrs;
    endfunction

    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int ceildiv(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/generic_stat_regs_counter.sv
// One event counter: per-cycle accumulate, ring load and optional clear-to-increment.
module stat_counter
    import generic_stat_regs_pkg::*;
#(
    parameter int CNTR_WIDTH = 32,
    parameter int INC_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INC_WIDTH-1:0]  inc,
    input  logic                  load,
    input  logic [CNTR_WIDTH-1:0] load_val,
    input  logic                  clr,
    output logic [CNTR_WIDTH-1:0] count
);

    logic [CNTR_WIDTH-1:0] inc_c;

    assign inc_c = CNTR_WIDTH'(inc);

    // A load wins over the increment; a clear keeps this cycle's increment so no event is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    count <= '0;
        else if (load) count <= load_val;
        else if (clr)  count <= inc_c;
        else           count <= count + inc_c;
    end

endmodule

// File: rtl/generic_stat_regs.sv
// Ring-attached block of event counters plus CPU-writable config regs, one registered hop.
// Define STAT_REGS_CLR_ON_READ_EN to make counter reads clear-on-read.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module generic_stat_regs
    import generic_stat_regs_pkg::*;
#(
    parameter int          UDP_REG_SRC_WIDTH = 2,
    parameter int          TAG               = 0,
    parameter int          REG_ADDR_WIDTH    = 5,
    parameter int          NUM_CNTRS         = 8,
    parameter int          NUM_SW_REGS       = 4,
    parameter int          CNTR_WIDTH        = 32,
    parameter int          INC_WIDTH         = 3,
    parameter logic [31:0] SW_REG_INIT       = 32'h0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              reg_req_in,
    input  logic                              reg_ack_in,
    input  logic                              reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in,
    output logic                              reg_req_out,
    output logic                              reg_ack_out,
    output logic                              reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out,
    input  logic [NUM_CNTRS*INC_WIDTH-1:0]    cntr_inc,
    output logic [NUM_SW_REGS*32-1:0]         sw_regs
);

    localparam int TAG_W    = `UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;
    localparam int NUM_REGS = NUM_CNTRS + NUM_SW_REGS;
    localparam int SW_BASE  = sw_base(NUM_CNTRS);

    logic [REG_ADDR_WIDTH-1:0]             loc;
    logic                                  hit;
    logic                                  rd;
    logic [NUM_CNTRS-1:0][CNTR_WIDTH-1:0]  cnt;
    logic [NUM_SW_REGS-1:0][31:0]          sw_q;
    logic [31:0]                           rd_data;

    assign loc = reg_addr_in[REG_ADDR_WIDTH-1:0];
    assign rd  = reg_rd_wr_L_in;
    assign hit = reg_req_in && !reg_ack_in
              && (reg_addr_in[`UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == TAG_W'(TAG))
              && (32'(loc) < 32'(NUM_REGS));

    for (genvar i = 0; i < NUM_CNTRS; i++) begin : g_cntr
        logic sel;
        assign sel = hit && (32'(loc) == 32'(CNTR_BASE + i));

        stat_counter #(
            .CNTR_WIDTH (CNTR_WIDTH),
            .INC_WIDTH  (INC_WIDTH)
        ) u_cntr (
            .clk      (clk),
            .reset    (reset),
            .inc      (cntr_inc[i*INC_WIDTH +: INC_WIDTH]),
            .load     (sel && !rd),
            .load_val (reg_data_in[CNTR_WIDTH-1:0]),
`ifdef STAT_REGS_CLR_ON_READ_EN
            .clr      (sel && rd),
`else
            .clr      (1'b0),
`endif
            .count    (cnt[i])
        );
    end

    // Counter reads see the value registered before this cycle's increment.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CNTRS; i++)
            if (32'(loc) == 32'(CNTR_BASE + i)) rd_data = 32'(cnt[i]);
        for (int j = 0; j < NUM_SW_REGS; j++)
            if (32'(loc) == 32'(SW_BASE + j)) rd_data = sw_q[j];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_q <= {NUM_SW_REGS{SW_REG_INIT}};
        end else begin
            for (int j = 0; j < NUM_SW_REGS; j++)
                if (hit && !rd && (32'(loc) == 32'(SW_BASE + j))) sw_q[j] <= reg_data_in;
        end
    end

    assign sw_regs = sw_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else begin
            reg_req_out     <= reg_req_in;
            reg_ack_out     <= reg_ack_in || hit;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= (hit && rd) ? rd_data : reg_data_in;
            reg_src_out     <= reg_src_in;
        end
    end

endmodule
